// File: rtl/noc_inject_buf.sv
// rtl/noc_inject_buf.sv - NoC source-node flit injection buffer with preloadable RAM
`timescale 1ns/1ps
module noc_inject_buf #(
    parameter int DATA_W  = 20,
    parameter int PKT_LEN = 30,
    parameter int NUM_PKT = 1,
    parameter int ADDR_W  = 5,
    parameter int REPEAT  = 0
) (
    input  logic              clk,
    input  logic              RST,
    input  logic              enable,
    input  logic              clear,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              out_ready,
    output logic [DATA_W-1:0] dataout,
    output logic              out_valid,
    output logic              out_sop,
    output logic              out_eop,
    output logic              busy,
    output logic              done
);

    localparam int                DEPTH     = PKT_LEN * NUM_PKT;
    localparam logic [ADDR_W:0]   DEPTH_W   = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(PKT_LEN - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_PAUSE,
        ST_DONE
    } state_t;

    state_t state_q, state_d;

    logic [DATA_W-1:0] mem [DEPTH];

    // Read-issue pointer, position within the current packet, and end-of-pass flag
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic [ADDR_W-1:0] pkt_idx_q, pkt_idx_d;
    logic              issued_all_q, issued_all_d;

    // Stage 1: RAM output register plus its per-flit tags
    logic [DATA_W-1:0] rd_data_q;
    logic              s1_valid_q, s1_sop_q, s1_eop_q, s1_last_q;

    // Stage 2: the presented flit
    logic [DATA_W-1:0] dataout_q;
    logic              out_valid_q, out_sop_q, out_eop_q, out_last_q;

    logic issue;
    logic s2_free;
    logic xfer_last;
    logic wr_ok;

    // Stage 2 can take a new flit when empty or when its flit leaves this edge;
    // a read is issued only when its result is guaranteed a free slot.
    always_comb begin
        s2_free   = !out_valid_q || out_ready;
        issue     = (state_q == ST_RUN) && enable && !issued_all_q
                    && (!s1_valid_q || s2_free);
        xfer_last = out_valid_q && out_ready && out_last_q;
        wr_ok     = wr_en && ((state_q == ST_IDLE) || (state_q == ST_DONE))
                    && ({1'b0, wr_addr} < DEPTH_W);
    end

    // Next-state, read pointer and packet index; clear overrides everything
    always_comb begin
        state_d      = state_q;
        rd_addr_d    = rd_addr_q;
        pkt_idx_d    = pkt_idx_q;
        issued_all_d = issued_all_q;
        if (clear) begin
            state_d      = ST_IDLE;
            rd_addr_d    = '0;
            pkt_idx_d    = '0;
            issued_all_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE:  if (enable) state_d = ST_RUN;
                ST_RUN: begin
                    if (xfer_last && (REPEAT == 0)) state_d = ST_DONE;
                    else if (!enable)               state_d = ST_PAUSE;
                end
                ST_PAUSE: begin
                    if (xfer_last && (REPEAT == 0)) state_d = ST_DONE;
                    else if (enable)                state_d = ST_RUN;
                end
                default:  state_d = state_q;
            endcase
            if (issue) begin
                pkt_idx_d = (pkt_idx_q == LAST_IDX) ? '0 : pkt_idx_q + 1'b1;
                if (rd_addr_q == LAST_ADDR) begin
                    rd_addr_d    = '0;
                    issued_all_d = (REPEAT == 0);
                end else begin
                    rd_addr_d = rd_addr_q + 1'b1;
                end
            end
        end
    end

    // Control state and read pointer registers
    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            state_q      <= ST_IDLE;
            rd_addr_q    <= '0;
            pkt_idx_q    <= '0;
            issued_all_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            rd_addr_q    <= rd_addr_d;
            pkt_idx_q    <= pkt_idx_d;
            issued_all_q <= issued_all_d;
        end
    end

    // Preload write port; the array itself is never reset
    always_ff @(posedge clk) begin
        if (wr_ok) mem[wr_addr] <= wr_data;
    end

    // Synchronous RAM read, held while no new read is issued
    always_ff @(posedge clk) begin
        if (issue) rd_data_q <= mem[rd_addr_q];
    end

    // Two-entry read pipeline: stage 1 tags follow the RAM read, stage 2 presents
    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            s1_valid_q  <= 1'b0;
            s1_sop_q    <= 1'b0;
            s1_eop_q    <= 1'b0;
            s1_last_q   <= 1'b0;
            dataout_q   <= '0;
            out_valid_q <= 1'b0;
            out_sop_q   <= 1'b0;
            out_eop_q   <= 1'b0;
            out_last_q  <= 1'b0;
        end else if (clear) begin
            s1_valid_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_sop_q   <= 1'b0;
            out_eop_q   <= 1'b0;
            out_last_q  <= 1'b0;
        end else begin
            if (s2_free) begin
                out_valid_q <= s1_valid_q;
                if (s1_valid_q) begin
                    dataout_q  <= rd_data_q;
                    out_sop_q  <= s1_sop_q;
                    out_eop_q  <= s1_eop_q;
                    out_last_q <= s1_last_q;
                end else begin
                    out_sop_q  <= 1'b0;
                    out_eop_q  <= 1'b0;
                    out_last_q <= 1'b0;
                end
            end
            if (issue) begin
                s1_valid_q <= 1'b1;
                s1_sop_q   <= (pkt_idx_q == '0);
                s1_eop_q   <= (pkt_idx_q == LAST_IDX);
                s1_last_q  <= (rd_addr_q == LAST_ADDR);
            end else if (s2_free) begin
                s1_valid_q <= 1'b0;
            end
        end
    end

    assign dataout   = dataout_q;
    assign out_valid = out_valid_q;
    assign out_sop   = out_sop_q;
    assign out_eop   = out_eop_q;
    assign busy      = (state_q == ST_RUN) || (state_q == ST_PAUSE);
    assign done      = (state_q == ST_DONE);

endmodule

// File: tb/tb_noc_inject_buf.sv
// tb/tb_noc_inject_buf.sv - randomized self-checking bench for noc_inject_buf
`timescale 1ns/1ps
module tb_noc_inject_buf;

    logic clk = 1'b0;
    logic RST;

    logic        a_en, a_clr, a_we, a_rdy;
    logic [4:0]  a_wa;
    logic [19:0] a_wd, a_dout;
    logic        a_vld, a_sop, a_eop, a_busy, a_done;

    logic        r_en, r_clr, r_we, r_rdy;
    logic [3:0]  r_wa;
    logic [19:0] r_wd, r_dout;
    logic        r_vld, r_sop, r_eop, r_busy, r_done;

    int n_tests = 0;
    int n_fail  = 0;

    logic [19:0] mem_a [30];
    logic [19:0] mem_r [12];
    int a_exp  = 0;
    int a_xfer = 0;
    int r_exp  = 0;
    int r_xfer = 0;
    logic        a_stall = 1'b0;
    logic [19:0] a_hold_d;
    logic        a_hold_sop, a_hold_eop;

    noc_inject_buf u_dut (
        .clk(clk), .RST(RST), .enable(a_en), .clear(a_clr),
        .wr_en(a_we), .wr_addr(a_wa), .wr_data(a_wd), .out_ready(a_rdy),
        .dataout(a_dout), .out_valid(a_vld), .out_sop(a_sop), .out_eop(a_eop),
        .busy(a_busy), .done(a_done)
    );

    noc_inject_buf #(.DATA_W(20), .PKT_LEN(4), .NUM_PKT(3), .ADDR_W(4), .REPEAT(1)) u_rep (
        .clk(clk), .RST(RST), .enable(r_en), .clear(r_clr),
        .wr_en(r_we), .wr_addr(r_wa), .wr_data(r_wd), .out_ready(r_rdy),
        .dataout(r_dout), .out_valid(r_vld), .out_sop(r_sop), .out_eop(r_eop),
        .busy(r_busy), .done(r_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_xfer(input int target, input int budget, output int cyc);
        cyc = 0;
        while (a_xfer < target && cyc < budget) begin
            tick();
            cyc++;
        end
        if (a_xfer < target) check("wait_xfer", 32'(a_xfer), 32'(target));
    endtask

    task automatic pulse_clear();
        a_clr = 1'b1;
        tick();
        a_clr = 1'b0;
    endtask

    // One-shot reference: flit k must be RAM[k] with sop/eop from k mod PKT_LEN
    always @(negedge clk) begin
        if (!RST) begin
            a_exp   = 0;
            a_stall = 1'b0;
        end else begin
            if (a_stall) begin
                check("hold_valid", 32'(a_vld), 32'd1);
                check("hold_data", 32'(a_dout), 32'(a_hold_d));
                check("hold_sop", 32'(a_sop), 32'(a_hold_sop));
                check("hold_eop", 32'(a_eop), 32'(a_hold_eop));
            end
            if (a_vld && a_rdy) begin
                check("overrun", 32'(a_exp < 30), 32'd1);
                check("data", 32'(a_dout), 32'(mem_a[a_exp % 30]));
                check("sop", 32'(a_sop), 32'(a_exp % 30 == 0));
                check("eop", 32'(a_eop), 32'(a_exp % 30 == 29));
                a_exp++;
                a_xfer++;
            end
            a_stall    = a_vld && !a_rdy && !a_clr;
            a_hold_d   = a_dout;
            a_hold_sop = a_sop;
            a_hold_eop = a_eop;
            if (a_clr) a_exp = 0;
        end
    end

    // Repeat-mode reference: flit k is RAM[k mod 12], packets of 4
    always @(negedge clk) begin
        if (!RST) begin
            r_exp = 0;
        end else begin
            if (r_vld && r_rdy) begin
                check("r_data", 32'(r_dout), 32'(mem_r[r_exp % 12]));
                check("r_sop", 32'(r_sop), 32'(r_exp % 4 == 0));
                check("r_eop", 32'(r_eop), 32'(r_exp % 4 == 3));
                r_exp++;
                r_xfer++;
            end
            if (r_clr) r_exp = 0;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base, b2, cyc;
        RST = 1'b0;
        a_en = 0; a_clr = 0; a_we = 0; a_rdy = 0; a_wa = '0; a_wd = '0;
        r_en = 0; r_clr = 0; r_we = 0; r_rdy = 0; r_wa = '0; r_wd = '0;
        tick();
        tick();
        check("rst_dout", 32'(a_dout), 32'd0);
        check("rst_valid", 32'(a_vld), 32'd0);
        check("rst_sop", 32'(a_sop), 32'd0);
        check("rst_eop", 32'(a_eop), 32'd0);
        check("rst_busy", 32'(a_busy), 32'd0);
        check("rst_done", 32'(a_done), 32'd0);
        check("r_rst_valid", 32'(r_vld), 32'd0);
        RST = 1'b1;
        tick();

        for (int k = 0; k < 30; k++) begin
            a_we = 1'b1; a_wa = 5'(k); a_wd = 20'(32'h100 + k);
            mem_a[k] = 20'(32'h100 + k);
            tick();
        end
        a_we = 1'b0;
        for (int k = 0; k < 12; k++) begin
            r_we = 1'b1; r_wa = 4'(k); r_wd = 20'(32'h200 + k);
            mem_r[k] = 20'(32'h200 + k);
            tick();
        end
        r_we = 1'b0;

        // Repeat mode: continuous streaming across the wrap, done never set
        r_rdy = 1'b1;
        r_en  = 1'b1;
        for (int i = 0; i < 30; i++) begin
            tick();
            check("r_done", 32'(r_done), 32'd0);
        end
        check("r_xfer", 32'(r_xfer), 32'd27);
        r_en  = 1'b0;
        r_clr = 1'b1;
        tick();
        r_clr = 1'b0;

        // One-shot, ready held high: latency, burst rate, done
        a_rdy = 1'b1;
        a_en  = 1'b1;
        base  = a_xfer;
        tick();
        check("lat0_valid", 32'(a_vld), 32'd0);
        check("lat0_busy", 32'(a_busy), 32'd1);
        tick();
        check("lat1_valid", 32'(a_vld), 32'd0);
        tick();
        check("lat2_valid", 32'(a_vld), 32'd1);
        check("first_data", 32'(a_dout), 32'h100);
        check("first_sop", 32'(a_sop), 32'd1);
        wait_xfer(base + 30, 100, cyc);
        check("burst_cycles", 32'(cyc), 32'd30);
        check("done_set", 32'(a_done), 32'd1);
        check("done_valid", 32'(a_vld), 32'd0);
        check("done_busy", 32'(a_busy), 32'd0);
        for (int i = 0; i < 5; i++) tick();
        check("no_rerun", 32'(a_xfer), 32'(base + 30));
        check("no_rerun_valid", 32'(a_vld), 32'd0);

        // Random backpressure
        pulse_clear();
        base = a_xfer;
        cyc  = 0;
        while (a_xfer < base + 30 && cyc < 600) begin
            a_rdy = 1'($urandom_range(0, 1));
            tick();
            cyc++;
        end
        a_rdy = 1'b1;
        check("rand_total", 32'(a_xfer - base), 32'd30);
        check("rand_done", 32'(a_done), 32'd1);

        // Pause at the 10th transfer
        pulse_clear();
        base = a_xfer;
        wait_xfer(base + 10, 100, cyc);
        a_en = 1'b0;
        b2   = a_xfer;
        for (int i = 0; i < 5; i++) tick();
        check("pause_drain", 32'(a_xfer - b2 <= 2), 32'd1);
        check("pause_busy", 32'(a_busy), 32'd1);
        check("pause_valid", 32'(a_vld), 32'd0);
        a_en = 1'b1;
        wait_xfer(base + 30, 100, cyc);
        check("pause_done", 32'(a_done), 32'd1);

        // Clear mid-stream, then restart from RAM[0]
        pulse_clear();
        base = a_xfer;
        wait_xfer(base + 7, 100, cyc);
        pulse_clear();
        check("clr_valid", 32'(a_vld), 32'd0);
        check("clr_busy", 32'(a_busy), 32'd0);
        base = a_xfer;
        wait_xfer(base + 30, 100, cyc);
        check("clr_done", 32'(a_done), 32'd1);

        // Asynchronous reset mid-stream, ignored write while busy
        pulse_clear();
        base = a_xfer;
        wait_xfer(base + 5, 100, cyc);
        RST = 1'b0;
        #1;
        check("arst_dout", 32'(a_dout), 32'd0);
        check("arst_valid", 32'(a_vld), 32'd0);
        check("arst_sop", 32'(a_sop), 32'd0);
        check("arst_eop", 32'(a_eop), 32'd0);
        check("arst_busy", 32'(a_busy), 32'd0);
        check("arst_done", 32'(a_done), 32'd0);
        tick();
        RST  = 1'b1;
        base = a_xfer;
        tick();
        check("rerun_busy", 32'(a_busy), 32'd1);
        a_we = 1'b1; a_wa = 5'd3; a_wd = 20'hABC;
        tick();
        a_we = 1'b0;
        wait_xfer(base + 30, 100, cyc);
        check("rerun_done", 32'(a_done), 32'd1);

        // Write accepted in DONE is delivered on the next pass
        a_we = 1'b1; a_wa = 5'd3; a_wd = 20'h5A5;
        mem_a[3] = 20'h5A5;
        tick();
        a_we = 1'b0;
        pulse_clear();
        base = a_xfer;
        wait_xfer(base + 30, 100, cyc);
        check("final_done", 32'(a_done), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/noc_inject_buf.md
Name: noc_inject_buf

Overview:
- Parametrised flit-injection buffer for NoC source nodes.
- Holds NUM_PKT packets of PKT_LEN flits each in an inferred synchronous-read RAM, preloaded through a write port.
- Streams the flits in address order onto a valid/ready link, with backpressure, packet head/tail marking, pause on enable drop, and one-shot or repeat mode.
- Replaces the per-node fixed-depth, IP-ROM injection buffers; one instance per router local port.

Parameters:
- DATA_W, 20, flit width in bits.
- PKT_LEN, 30, flits per packet (>=1).
- NUM_PKT, 1, packets stored (>=1); DEPTH = PKT_LEN*NUM_PKT.
- ADDR_W, 5, address width; must satisfy 2**ADDR_W >= DEPTH.
- REPEAT, 0, 0 = one-shot then DONE; 1 = wrap to address 0 and continue.

Ports:
- clk  in  1  clock.
- RST  in  1  asynchronous reset, active-low.
- enable  in  1  level; run/continue injection while high.
- clear  in  1  synchronous; abort and return to IDLE; address reset to 0.
- wr_en  in  1  RAM preload strobe.
- wr_addr  in  ADDR_W  preload address.
- wr_data  in  DATA_W  preload data.
- out_ready  in  1  downstream accepts flit.
- dataout  out  DATA_W  flit data.
- out_valid  out  1  dataout valid.
- out_sop  out  1  flit is packet head (index 0 of a packet); qualified by out_valid.
- out_eop  out  1  flit is packet tail (index PKT_LEN-1); qualified by out_valid.
- busy  out  1  state RUN or PAUSE.
- done  out  1  sticky; one-shot pass complete.

Behaviour:
- Reset: state IDLE, read address 0, out_valid=0, out_sop=0, out_eop=0, busy=0, done=0, dataout=0. RAM contents are not reset.
- Transfer: a flit is transferred on a clk edge with out_valid=1 and out_ready=1.
- While out_valid=1 and out_ready=0, dataout, out_sop and out_eop hold stable.
- out_valid never drops without a transfer, except on clear or reset.
- FSM states: IDLE, RUN, PAUSE, DONE.
  - IDLE->RUN: enable sampled high.
  - RUN->PAUSE: enable sampled low.
  - PAUSE->RUN: enable sampled high.
  - RUN->DONE: transfer of flit DEPTH-1 when REPEAT=0.
  - DONE: holds until clear or reset; enable is ignored.
  - Any state->IDLE: clear=1. clear has priority over all other events on the same edge.
- Latency: first out_valid is asserted exactly 2 cycles after the edge that samples enable high (1 cycle address issue, 1 cycle RAM read).
- Throughput: with out_ready held high, 1 flit/clk, no bubbles, including across packet boundaries and the REPEAT wrap.
- Stall: under backpressure the read pipeline must not lose or duplicate flits. The implementation may use a skid register of at most 2 entries.
- Pause: in PAUSE no new RAM reads are issued. Flits already read, up to 2, are still presented and must be drained by out_ready. Resume continues at the next unsent address.
- Addressing:
  - Flit k is RAM[k], for k = 0..DEPTH-1.
  - out_sop = (k mod PKT_LEN == 0); out_eop = (k mod PKT_LEN == PKT_LEN-1).
  - PKT_LEN=1 gives sop=eop=1 on every flit.
- REPEAT=1: after address DEPTH-1 the next read is address 0; done is never set.
- done rises on the edge of the final transfer, the same edge out_valid falls (if no other flit is pending).
- Writes:
  - Accepted only in IDLE or DONE, and only if wr_addr < DEPTH; otherwise ignored.
  - A write lands on the edge it is sampled. A read issued on the following edge returns the new data.
- Reset mid-operation: all outputs return to reset values asynchronously. On release the block is in IDLE.

Test Plan:
- Preload RAM[k]=k+0x100 for DEPTH=30, NUM_PKT=1, hold out_ready=1, pulse enable high for 1 cycle then keep it high -> out_valid rises 2 cycles after enable; 30 consecutive flits 0x100..0x11D; sop only on 0x100, eop only on 0x11D; done=1 afterwards; a second enable produces no output.
- Same preload, drive out_ready pseudo-random at 50% -> the accepted sequence is exactly 0x100..0x11D with no gaps or repeats; dataout is stable on every stalled cycle.
- Drop enable at the 10th transfer for 5 cycles -> at most 2 further flits appear; after enable returns, streaming resumes at the correct next value; total count is 30.
- NUM_PKT=3, PKT_LEN=4, REPEAT=1, out_ready=1 for 30 cycles -> sop on flits 0,4,8 and then flit 12 is RAM[0] (wrap) with sop; done stays 0.
- Assert clear mid-stream at flit 7, then re-enable -> out_valid drops on the next edge; restart delivers RAM[0] with sop.
- Assert RST low mid-stream, then issue wr_en to address 3 while busy -> all outputs zero immediately. After re-run (write during busy ignored): RAM[3] is unchanged. A write in DONE, then clear and enable -> new RAM[3] data is delivered.
